// File: rtl/alu_status_reg_m.sv
// Processor status word register for the XMakina core: derives flags from the
// arithmetic block, accepts explicit writes, and keeps a shadow stack of PSWs.
module alu_status_reg_m #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WORD_SIZE-1:0]         alu_result,
  input  logic                         alu_carry,
  input  logic                         alu_ovf,
  input  logic                         byte_op,
  input  logic                         flag_upd,
  input  logic [3:0]                   flag_mask,
  input  logic                         psw_we,
  input  logic [15:0]                  psw_wdata,
  input  logic                         push,
  input  logic [2:0]                   push_prio,
  input  logic                         pop,
  output logic [15:0]                  psw,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         fault
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic       flt;
    logic [2:0] prio;
    logic       v;
    logic       slp;
    logic       n;
    logic       z;
    logic       c;
  } psw_t;

  psw_t          psw_q, psw_d, flag_psw;
  psw_t          stack [2**AW];
  logic [DW-1:0] depth_q, depth_d;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          stack_we, full, empty, z_flag, n_flag;
  logic          unused_wdata;

  // Bits [15:9] of a PSW write are architecturally ignored.
  assign unused_wdata = ^psw_wdata[15:9];

  assign full   = (depth_q == DW'(DEPTH));
  assign empty  = (depth_q == '0);
  assign wr_idx = depth_q[AW-1:0];
  assign rd_idx = wr_idx - 1'b1;

  // Candidate PSW after a masked flag update; SLP, PRIO and FLT pass through.
  always_comb begin
    z_flag   = byte_op ? (alu_result[7:0] == 8'h00) : (alu_result == '0);
    n_flag   = byte_op ? alu_result[7] : alu_result[WORD_SIZE-1];
    flag_psw = psw_q;
    if (flag_mask[0]) flag_psw.c = alu_carry;
    if (flag_mask[1]) flag_psw.z = z_flag;
    if (flag_mask[2]) flag_psw.n = n_flag;
    if (flag_mask[3]) flag_psw.v = alu_ovf;
  end

  // Priority: pop > push > psw_we > flag_upd; conflicting requests raise FLT.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    psw_d    = psw_q;
    depth_d  = depth_q;
    stack_we = 1'b0;
    if (pop && push) begin
      if (flag_upd) psw_d = flag_psw;
      psw_d.flt = 1'b1;
    end else if (pop) begin
      if (!empty) begin
        psw_d     = stack[rd_idx];
        psw_d.flt = stack[rd_idx].flt | psw_q.flt;
        depth_d   = depth_q - 1'b1;
      end
      if (empty || psw_we) psw_d.flt = 1'b1;
    end else if (push) begin
      psw_d      = flag_upd ? flag_psw : psw_q;
      psw_d.prio = push_prio;
      psw_d.slp  = 1'b0;
      if (!full) begin
        stack_we = 1'b1;
        depth_d  = depth_q + 1'b1;
      end
      if (full || psw_we) psw_d.flt = 1'b1;
    end else if (psw_we) begin
      psw_d = psw_t'(psw_wdata[8:0]);
    end else if (flag_upd) begin
      psw_d = flag_psw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psw_q   <= '0;
      depth_q <= '0;
    end else begin
      psw_q   <= psw_d;
      depth_q <= depth_d;
    end
  end

  // NOTE: the stack array has no reset; entries are only read below depth, so
  // stale contents are never observed and the array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (stack_we) stack[wr_idx] <= psw_q;
  end

  assign psw   = {7'b0, psw_q};
  assign depth = depth_q;
  assign fault = psw_q.flt;

endmodule

// File: tb/tb_alu_status_reg_m.sv
// Scoreboard bench for alu_status_reg_m: driver pushes reference-model results,
// a monitor pops and compares them one cycle later.
module tb_alu_status_reg_m;

  localparam int WORD_SIZE = 16;
  localparam int DEPTH     = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] alu_result;
  logic        alu_carry, alu_ovf, byte_op, flag_upd;
  logic [3:0]  flag_mask;
  logic        psw_we;
  logic [15:0] psw_wdata;
  logic        push, pop;
  logic [2:0]  push_prio;
  logic [15:0] psw;
  logic [2:0]  depth;
  logic        fault;

  alu_status_reg_m #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_ovf(alu_ovf), .byte_op(byte_op), .flag_upd(flag_upd), .flag_mask(flag_mask),
    .psw_we(psw_we), .psw_wdata(psw_wdata), .push(push), .push_prio(push_prio),
    .pop(pop), .psw(psw), .depth(depth), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] psw;
    logic [2:0]  depth;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] m_psw;
  logic [8:0] m_stack[$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_psw = '0;
    m_stack.delete();
  endtask

  // Drive one cycle of stimulus and record what the PSW/stack must become.
  task automatic step(input logic [15:0] res, input logic c, input logic v, input logic b,
                      input logic fu, input logic [3:0] mask, input logic we,
                      input logic [15:0] wd, input logic ps, input logic [2:0] pr,
                      input logic pp);
    logic [8:0] f, saved;
    logic       z, n, old_flt;
    exp_t       e;
    @(negedge clk);
    alu_result = res; alu_carry = c; alu_ovf = v; byte_op = b; flag_upd = fu;
    flag_mask = mask; psw_we = we; psw_wdata = wd; push = ps; push_prio = pr; pop = pp;

    z = b ? ((res & 16'h00FF) == 0) : (res == 0);
    n = b ? res[7] : res[15];
    f = m_psw;
    if (mask[0]) f[0] = c;
    if (mask[1]) f[1] = z;
    if (mask[2]) f[2] = n;
    if (mask[3]) f[4] = v;

    if (pp && ps) begin
      if (fu) m_psw = f;
      m_psw[8] = 1'b1;
    end else if (pp) begin
      if (m_stack.size() > 0) begin
        old_flt  = m_psw[8];
        m_psw    = m_stack.pop_back();
        m_psw[8] = m_psw[8] | old_flt;
      end else begin
        m_psw[8] = 1'b1;
      end
      if (we) m_psw[8] = 1'b1;
    end else if (ps) begin
      saved = m_psw;
      if (fu) m_psw = f;
      m_psw[7:5] = pr;
      m_psw[3]   = 1'b0;
      if (m_stack.size() < DEPTH) m_stack.push_back(saved);
      else m_psw[8] = 1'b1;
      if (we) m_psw[8] = 1'b1;
    end else if (we) begin
      m_psw = wd[8:0];
    end else if (fu) begin
      m_psw = f;
    end
    e.psw   = {7'b0, m_psw};
    e.depth = 3'(m_stack.size());
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    alu_result = '0; alu_carry = 0; alu_ovf = 0; byte_op = 0; flag_upd = 0;
    flag_mask = '0; psw_we = 0; psw_wdata = '0; push = 0; push_prio = '0; pop = 0;
  endtask

  // Absolute check of the state right after the next rising edge.
  task automatic expect_now(input string name, input logic [15:0] p, input logic [2:0] d);
    @(posedge clk);
    #2;
    check({name, "_psw"}, psw, p);
    check({name, "_depth"}, 16'(depth), 16'(d));
    check({name, "_fault"}, 16'(fault), 16'(p[8]));
  endtask

  task automatic do_push(input logic [2:0] pr);
    step(16'h0, 0, 0, 0, 0, 4'h0, 0, 16'h0, 1, pr, 0);
  endtask

  task automatic do_pop();
    step(16'h0, 0, 0, 0, 0, 4'h0, 0, 16'h0, 0, 3'd0, 1);
  endtask

  // Monitor: outputs are valid every cycle, compared #1 after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_psw", psw, e.psw);
        check("sb_depth", 16'(depth), 16'(e.depth));
        check("sb_fault", 16'(fault), 16'(e.psw[8]));
      end
    end
  end

  initial begin
    logic [15:0] r;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #3;
    check("reset_psw", psw, 16'h0000);
    check("reset_depth", 16'(depth), 16'h0);
    check("reset_fault", 16'(fault), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step(16'h0000, 1, 0, 0, 1, 4'hF, 0, 16'h0, 0, 3'd0, 0);
    expect_now("word_add", 16'h0003, 3'd0);
    step(16'h1280, 0, 1, 1, 1, 4'b0110, 0, 16'h0, 0, 3'd0, 0);
    expect_now("byte_neg", 16'h0005, 3'd0);
    step(16'h1280, 0, 1, 0, 1, 4'b0110, 0, 16'h0, 0, 3'd0, 0);
    expect_now("word_pos", 16'h0001, 3'd0);

    do_push(3'd3);
    do_push(3'd5);
    expect_now("push2", 16'h00A1, 3'd2);
    do_pop();
    expect_now("pop1", 16'h0061, 3'd1);
    do_pop();
    expect_now("pop2", 16'h0001, 3'd0);

    for (int i = 1; i <= 4; i++) do_push(3'(i));
    expect_now("full", 16'h0081, 3'd4);
    do_push(3'd5);
    expect_now("overflow", 16'h01A1, 3'd4);
    for (int i = 0; i < 4; i++) do_pop();
    do_pop();
    expect_now("underflow", 16'h0101, 3'd0);

    step(16'h0000, 0, 0, 0, 1, 4'hF, 1, 16'h00FF, 0, 3'd0, 0);
    expect_now("we_vs_flag", 16'h00FF, 3'd0);
    step(16'h0, 0, 0, 0, 0, 4'h0, 1, 16'hFFFF, 0, 3'd0, 0);
    expect_now("we_upper", 16'h01FF, 3'd0);
    step(16'h0, 0, 0, 0, 0, 4'h0, 1, 16'h0000, 0, 3'd0, 0);
    do_push(3'd2);
    step(16'h0, 0, 0, 0, 0, 4'h0, 0, 16'h0, 1, 3'd7, 1);
    expect_now("push_pop", 16'h0140, 3'd1);

    for (int i = 0; i < 400; i++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 3) == 0) r[7:0] = 8'h00;
      if ($urandom_range(0, 5) == 0) r = 16'h0000;
      step(r, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
           $urandom_range(0, 9) == 0, 16'($urandom),
           $urandom_range(0, 3) == 0, 3'($urandom), $urandom_range(0, 4) == 0);
    end
    idle_inputs();
    @(posedge clk);
    #2;
    check("sb_drained", 16'(sb.size()), 16'h0);

    // Asynchronous reset landing in the middle of a push with two entries stacked.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_push(3'd6);
    do_push(3'd4);
    expect_now("pre_reset", 16'h0080, 3'd2);
    @(negedge clk);
    push = 1'b1;
    push_prio = 3'd7;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_psw", psw, 16'h0000);
    check("async_depth", 16'(depth), 16'h0);
    check("async_fault", 16'(fault), 16'h0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
    step(16'h8000, 0, 1, 0, 1, 4'hF, 0, 16'h0, 0, 3'd0, 0);
    expect_now("post_reset", 16'h0014, 3'd0);
    @(negedge clk);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_status_reg_m.md
# alu_status_reg_m

Processor status word (PSW) register for the multi-cycle XMakina core. It sits directly downstream of the arithmetic block and captures that block's `result`, `carry` and `ovf` outputs, with byte/word awareness. It derives Z and N, applies per-flag update masks and handles explicit PSW writes from the control unit. It also keeps a small hardware shadow stack of PSWs for interrupt entry and exit.

## Interface
- `WORD_SIZE`, 16: ALU operand width; must be even.
- `DEPTH`, 4: shadow stack entries, at least 1.
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `alu_result`  in  WORD_SIZE  result from the arithmetic block.
- `alu_carry`  in  1  carry out, already byte/word selected.
- `alu_ovf`  in  1  overflow, already byte/word selected.
- `byte_op`  in  1  1 = the current ALU op is a byte op.
- `flag_upd`  in  1  strobe: update flags from the ALU this cycle.
- `flag_mask`  in  4  per-flag enable, order {V,N,Z,C}; a 0 holds that flag.
- `psw_we`  in  1  explicit PSW write.
- `psw_wdata`  in  16  write data for the PSW.
- `push`  in  1  interrupt entry: save the PSW and load the new priority.
- `push_prio`  in  3  priority loaded on `push`.
- `pop`  in  1  return from interrupt: restore the PSW.
- `psw`  out  16  registered PSW.
- `depth`  out  $clog2(DEPTH+1)  number of stack entries in use.
- `fault`  out  1  equal to `psw[8]`.

## Operation
- PSW layout:
  - [0] C, [1] Z, [2] N, [3] SLP, [4] V.
  - [7:5] PRIO.
  - [8] FLT, sticky.
  - [15:9] read as 0; writes to these bits are ignored.
- Flag derivation on `flag_upd`:
  - Byte op: Z = (alu_result[7:0]==0), N = alu_result[7].
  - Word op: Z = (alu_result==0), N = alu_result[WORD_SIZE-1].
  - C = alu_carry, V = alu_ovf.
  - Each flag is written only where its `flag_mask` bit is 1.
  - SLP, PRIO and FLT are never touched by `flag_upd`.
- `psw_we`: PSW <= psw_wdata[8:0], with the upper bits forced to 0. This clears or sets FLT as written.
- `push`, stack not full:
  - stack[depth] <= current registered PSW; depth+1.
  - Live PSW: PRIO <= push_prio, SLP <= 0.
  - If `flag_upd` is asserted in the same cycle, the flag update is also applied to the live PSW. The saved copy is the pre-update value.
- `push`, stack full: the stack and depth are unchanged, FLT <= 1, and the PRIO/SLP load still happens.
- `pop`, stack not empty: PSW <= stack[depth-1] (FLT is the OR of the restored value and the current FLT); depth-1. Any `flag_upd` in that cycle is ignored.
- `pop`, stack empty: the PSW is unchanged except FLT <= 1; depth stays 0.
- `push` and `pop` in the same cycle: neither is performed, FLT <= 1, and `flag_upd` is still applied.
- Priority within one cycle: `pop` > `push` > `psw_we` > `flag_upd`.
  - `psw_we` together with `push` or `pop`: `psw_we` is ignored and FLT <= 1.
  - `psw_we` together with `flag_upd`: `psw_we` wins for every bit.
- No state machine. State is the PSW register, the stack array and the depth counter. The counter saturates at 0 and at DEPTH; it never wraps.

## Timing
- All outputs are registered. An event sampled at edge N is visible on `psw`/`depth` after edge N, so latency is 1 cycle.
- `flag_upd`, `push`, `pop` and `psw_we` are single-cycle strobes. Holding one for k cycles performs k operations.
- ALU inputs must be stable in the cycle `flag_upd` is high. The arithmetic block is combinational, so operands must not change in that cycle.
- Reset (asynchronous assert, synchronous release):
  - psw = 16'h0000, depth = 0, fault = 0.
  - Stack contents are don't-care.
- Reset mid-push or mid-pop aborts the operation; no partial update survives.

## Test plan
- Word add: alu_result=16'h0000, carry=1, ovf=0, byte_op=0, mask=4'hF, flag_upd -> next cycle psw[4:0]=5'b00011 (Z=1, C=1).
- Byte op: alu_result=16'h1280, byte_op=1, mask=4'b0110 -> N=1, Z=0, C and V unchanged. Same data with byte_op=0 -> N=0.
- Push twice with prio 3 then 5 -> depth=2, PRIO=5. Pop -> PRIO=3, depth=1. Pop -> original PSW, depth=0, fault=0.
- DEPTH=4: five pushes -> depth=4 and fault=1 after the fifth. Then pop on empty after draining -> fault=1, depth=0.
- Same cycle: psw_we=16'h00FF with flag_upd -> psw=16'h00FF. push with pop -> depth unchanged, fault=1.
- Drop rst_n asynchronously mid-push with depth=2 -> psw=0 and depth=0 before the next clk edge.
